// File: rtl/sub_pkg.sv
// sub_pkg: shared state encoding and default width for the serial subtractor
package sub_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} sub_state_t;
    localparam int SUB_WIDTH_DEFAULT = 8;
endpackage

// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: start/busy/done handshake plus operand and result bus
interface serial_subtractor_if #(parameter int WIDTH = sub_pkg::SUB_WIDTH_DEFAULT);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    modport master (output start, a, b, bin, input busy, done, diff, bout);
    modport slave  (input start, a, b, bin, output busy, done, diff, bout);
endinterface

// File: rtl/full_subtractor.sv
// full_subtractor: gate-level cell, two half subtractors joined by an or gate
module full_subtractor (
    output logic diff,
    output logic bout,
    input  logic A,
    input  logic B,
    input  logic bin
);
    logic d1, na, b1, nd1, b2;
    xor g_hs0_d (d1, A, B);
    not g_hs0_n (na, A);
    and g_hs0_b (b1, na, B);
    xor g_hs1_d (diff, d1, bin);
    not g_hs1_n (nd1, d1);
    and g_hs1_b (b2, nd1, bin);
    or  g_bo    (bout, b1, b2);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin over WIDTH cycles, LSB first
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
    input logic               clk,
    input logic               rst_n,
    serial_subtractor_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    sub_state_t       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh, b_sh, d_sh, d_next;
    logic             borrow, d, bo;
    full_subtractor u_fs (.diff(d), .bout(bo), .A(a_sh[0]), .B(b_sh[0]), .bin(borrow));
    // new bit enters at the MSB so after WIDTH steps bit 0 sits at the LSB
    assign d_next = WIDTH'({d, d_sh} >> 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            a_sh     <= '0;
            b_sh     <= '0;
            d_sh     <= '0;
            borrow   <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.diff <= '0;
            bus.bout <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    a_sh     <= bus.a;
                    b_sh     <= bus.b;
                    borrow   <= bus.bin;
                    cnt      <= '0;
                    state    <= RUN;
                    bus.busy <= 1'b1;
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    d_sh   <= d_next;
                    borrow <= bo;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        bus.diff <= d_next;
                        bus.bout <= bo;
                        bus.done <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and random checks of WIDTH=8 and WIDTH=1 instances against a timing model
module tb_serial_subtractor;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(8)) i8 ();
    serial_subtractor_if #(.WIDTH(1)) i1 ();
    serial_subtractor #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(i8));
    serial_subtractor #(.WIDTH(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(i1));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: an accepted op stays busy for WIDTH+1 cycles, result appears after WIDTH edges.
    bit act8, act1;
    int p8, p1;
    logic [8:0] r8;
    logic [1:0] r1;
    logic [7:0] ed8;
    logic eb8, ed1, eb1;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act8 = 0; p8 = 0; ed8 = '0; eb8 = 0;
        end else if (!act8) begin
            if (i8.start) begin
                act8 = 1; p8 = 0;
                r8 = {1'b0, i8.a} - {1'b0, i8.b} - 9'(i8.bin);
            end
        end else begin
            p8++;
            if (p8 == 8) {eb8, ed8} = r8;
            if (p8 == 9) act8 = 0;
        end
    end
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act1 = 0; p1 = 0; ed1 = 0; eb1 = 0;
        end else if (!act1) begin
            if (i1.start) begin
                act1 = 1; p1 = 0;
                r1 = {1'b0, i1.a} - {1'b0, i1.b} - 2'(i1.bin);
            end
        end else begin
            p1++;
            if (p1 == 1) {eb1, ed1} = r1;
            if (p1 == 2) act1 = 0;
        end
    end

    always @(negedge clk) begin
        chk("busy8", 32'(i8.busy), 32'(act8));
        chk("done8", 32'(i8.done), 32'(act8 && p8 == 8));
        chk("diff8", 32'(i8.diff), 32'(ed8));
        chk("bout8", 32'(i8.bout), 32'(eb8));
        chk("busy1", 32'(i1.busy), 32'(act1));
        chk("done1", 32'(i1.done), 32'(act1 && p1 == 1));
        chk("diff1", 32'(i1.diff), 32'(ed1));
        chk("bout1", 32'(i1.bout), 32'(eb1));
    end

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bi, input bit lit,
                       input logic [7:0] xd, input logic xb, input bit prev, input logic [7:0] xp);
        int n = 0;
        i8.a = a; i8.b = b; i8.bin = bi; i8.start = 1'b1;
        @(posedge clk); #1;
        i8.start = 1'b0; i8.a = 8'($urandom); i8.b = 8'($urandom); i8.bin = 1'($urandom);
        while (!i8.done && n < 20) begin
            if (prev && n == 4) chk("hold_prev", 32'(i8.diff), 32'(xp));
            @(posedge clk); #1;
            n++;
        end
        if (!i8.done) chk("timeout8", 32'(n), 32'(8));
        else if (lit) begin
            chk("lat8", 32'(n), 32'(8));
            chk("lit_diff8", 32'(i8.diff), 32'(xd));
            chk("lit_bout8", 32'(i8.bout), 32'(xb));
        end
        @(posedge clk); #1;
        if (lit) chk("idle8", 32'(i8.busy), 32'(0));
    endtask

    task automatic op1(input logic a, input logic b, input logic bi, input logic xd, input logic xb);
        int n = 0;
        i1.a = a; i1.b = b; i1.bin = bi; i1.start = 1'b1;
        @(posedge clk); #1;
        i1.start = 1'b0;
        while (!i1.done && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk("lat1", 32'(n), 32'(1));
        chk("lit_diff1", 32'(i1.diff), 32'(xd));
        chk("lit_bout1", 32'(i1.bout), 32'(xb));
        @(posedge clk); #1;
    endtask

    initial begin
        logic [7:0] dt, bt;
        int rises[$];
        logic pb;
        int n;
        dt = 8'b1001_0110;
        bt = 8'b1000_1110;
        i8.start = 0; i8.a = '0; i8.b = '0; i8.bin = 0;
        i1.start = 0; i1.a = '0; i1.b = '0; i1.bin = 0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_busy", 32'(i8.busy), 32'(0));
        chk("rst_diff", 32'(i8.diff), 32'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        op8(8'h5A, 8'h3C, 1'b0, 1, 8'h1E, 1'b0, 0, 8'h00);
        op8(8'h00, 8'h01, 1'b0, 1, 8'hFF, 1'b1, 0, 8'h00);
        op8(8'h10, 8'h0F, 1'b1, 1, 8'h00, 1'b0, 1, 8'hFF);
        op8(8'hFF, 8'hFF, 1'b1, 1, 8'hFF, 1'b1, 0, 8'h00);

        pb = 0;
        i8.start = 1'b1;
        for (int c = 0; c < 30; c++) begin
            i8.a = 8'($urandom); i8.b = 8'($urandom); i8.bin = 1'($urandom);
            @(posedge clk); #1;
            if (i8.busy && !pb) rises.push_back(c);
            pb = i8.busy;
        end
        i8.start = 1'b0;
        chk("held_rises", 32'(rises.size()), 32'(3));
        for (int k = 1; k < rises.size(); k++) chk("held_gap", 32'(rises[k] - rises[k-1]), 32'(10));
        n = 0;
        while (i8.busy && n < 20) begin @(posedge clk); #1; n++; end
        chk("held_drain", 32'(i8.busy), 32'(0));

        i8.a = 8'hC3; i8.b = 8'h21; i8.bin = 1'b0; i8.start = 1'b1;
        @(posedge clk); #1;
        i8.start = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(i8.busy), 32'(0));
        chk("abort_done", 32'(i8.done), 32'(0));
        chk("abort_diff", 32'(i8.diff), 32'(0));
        chk("abort_bout", 32'(i8.bout), 32'(0));
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        op8(8'h80, 8'h01, 1'b0, 1, 8'h7F, 1'b0, 0, 8'h00);

        for (int k = 0; k < 8; k++) begin
            logic [2:0] v;
            v = 3'(k);
            op1(v[2], v[1], v[0], dt[k], bt[k]);
        end

        for (int k = 0; k < 1000; k++)
            op8(8'($urandom), 8'($urandom), 1'($urandom), 0, 8'h00, 1'b0, 0, 8'h00);

        @(posedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial subtractor computing `diff = a - b - bin` over WIDTH clock cycles, one bit per cycle, LSB first, using a single gate-level full-subtractor cell. It is the inverse-operation counterpart of the library's full-adder datapath, and the first sequential arithmetic block in the gate library. A start/busy/done handshake lets a controller launch an operation and collect a registered result plus final borrow.

## Interface

Parameters:
- `WIDTH`, default 8: operand and result width in bits. Legal range is WIDTH ≥ 1.

Ports (name, direction, width, meaning):
- `clk`  input  1: single clock; all state changes on the rising edge.
- `rst_n`  input  1: reset, asynchronous, active-low.
- `start`  input  1: request a new operation; sampled only in IDLE.
- `a`  input  WIDTH: minuend; captured when start is accepted.
- `b`  input  WIDTH: subtrahend; captured when start is accepted.
- `bin`  input  1: borrow-in; captured when start is accepted.
- `busy`  output  1: high while an operation is in progress (RUN or DONE).
- `done`  output  1: one-cycle pulse marking that the result is valid.
- `diff`  output  WIDTH: registered result, `(a - b - bin) mod 2^WIDTH`.
- `bout`  output  1: registered final borrow; 1 iff `a < b + bin` (unsigned).

## Operation

FSM has three states: IDLE, RUN, DONE.

- **IDLE**
  - `start`=1 at an edge captures `a`/`b` into shift registers `a_sh`/`b_sh`, loads the borrow flop with `bin`, clears bit counter `cnt`, and moves to RUN.
  - `start`=0 holds IDLE.
- **RUN**, each edge:
  - `full_subtractor(x=a_sh[0], y=b_sh[0], bi=borrow)` produces `d` and `bo`.
  - Work register `d_sh` shifts right with `d` inserted at the MSB.
  - `a_sh` and `b_sh` shift right.
  - `borrow <= bo`; `cnt <= cnt+1`.
  - On the edge where `cnt == WIDTH-1`:
    - the step is still performed;
    - `diff` is loaded with the completed `d_sh` value, including this edge's `d`;
    - `bout <= bo`;
    - the FSM moves to DONE.
- **DONE**: `done`=1 for exactly one cycle, then the FSM returns to IDLE unconditionally.

Cell equations: `d = x ^ y ^ bi`; `bo = (~x & y) | (~(x ^ y) & bi)`.

Handshake rules:
- `start` is ignored in RUN and DONE. There is no queueing, and captured operands are unaffected.
- `a`, `b` and `bin` are don't-care except at the accepting edge.
- `diff` and `bout` change only on the completing edge. They hold the previous result through IDLE and RUN, and hold the new result until the next completion.

Width rules:
- `cnt` is `$clog2(WIDTH+1)` bits wide (minimum 1).
- Arithmetic is modulo 2^WIDTH; the only overflow indication is `bout`.

Reset:
- `rst_n`=0 forces IDLE with `busy`=0, `done`=0, `diff`=0, `bout`=0, and clears the internal registers.
- Reset mid-operation aborts the operation: no `done`, and `diff` reads 0.

## Timing

- Accepting edge E0: `busy` is high from after E0 until after edge E0+WIDTH+1.
- Bit *i* is computed at edge E0+1+i.
- `diff`/`bout` update at edge E0+WIDTH.
- `done` is high in the cycle between edges E0+WIDTH and E0+WIDTH+1.
- Fastest back-to-back: the next `start` is accepted at edge E0+WIDTH+2, giving a throughput of one operation per WIDTH+2 cycles.
- WIDTH=1: RUN lasts one edge; `done` is high after edge E0+1.
- `busy` and `done` are registered FSM decodes with no combinational path from inputs.

## Structure

- Shared package `sub_pkg`:
  - state typedef `sub_state_t` = {IDLE, RUN, DONE}, 2-bit encoding 0/1/2;
  - default-width constant `SUB_WIDTH_DEFAULT` = 8.
- Sub-module `full_subtractor` (output `diff`, `bout`; input `A`, `B`, `bin`):
  - gate-level, built from the library's xor/and/or/not gates;
  - composed as two half subtractors plus an or gate, mirroring the adder structure;
  - one instance only.
- `serial_subtractor` contains the FSM, counter, shift registers, borrow flop and output registers.

## Test plan

- WIDTH=8, a=0x5A, b=0x3C, bin=0, start at E0 → `diff`=0x1E, `bout`=0, `done` high only in the cycle after E0+8, `busy` low after E0+9.
- WIDTH=8, a=0x00, b=0x01, bin=0 → `diff`=0xFF, `bout`=1. Then a=0x10, b=0x0F, bin=1 → `diff`=0x00, `bout`=0. The previous result stays visible until edge E0+8 of the second operation.
- Start held high continuously with new operands each cycle → only operands present at each accepting edge are used; the accepting edges are spaced exactly WIDTH+2 apart.
- Assert `rst_n`=0 asynchronously mid-RUN (after bit 3) → `busy`, `done`, `diff` and `bout` go to 0 immediately; no `done` pulse; the next start runs normally.
- WIDTH=1: exhaustive over a, b, bin (8 cases) → `diff`/`bout` match the truth table; `done` high after E0+1.
- WIDTH=8, 1000 random a/b/bin compared against a reference model `{bout,diff} = {1'b0,a} - b - bin`, with `bout` taken as the sign bit → zero mismatches.
